// File: rtl/fifo_to_mem_pkg.sv
// Shared constants and types for the QDR write path (fifo_to_mem) and its arbiter.
package fifo_to_mem_pkg;
  localparam int NUM_QUEUES         = 4;
  localparam int QID_W              = 2;
  localparam int DEF_MEM_DATA_WIDTH = 36;
  // One QDR beat carries a low and a high half: 2 * MEM_DATA_WIDTH bits.
  localparam int BEAT_W             = 2 * DEF_MEM_DATA_WIDTH;

  typedef enum logic {
    S_B0 = 1'b0,  // idle / may grant, issues beat 0 on the next cycle
    S_B1 = 1'b1   // beat 1 of the burst goes out on the next cycle
  } state_e;
endpackage

// File: rtl/fifo_to_mem_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: lowest-offset eligible queue
// after last_grant wins. Shared with the replay read engine.
module rr_arbiter4
  import fifo_to_mem_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] elig,
  input  logic [QID_W-1:0]      last_grant,
  output logic                  grant_vld,
  output logic [QID_W-1:0]      grant_qid
);

  // Scan offsets 4..1 so the smallest offset (highest priority) is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant_qid = last_grant;
    for (int i = NUM_QUEUES; i >= 1; i--) begin
      if (elig[last_grant + QID_W'(i)]) begin
        grant_vld = 1'b1;
        grant_qid = last_grant + QID_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_to_mem.sv
// Drains four FWFT ingress FIFOs into per-queue QDR regions as two-beat bursts
// and advances each queue's tail pointer. Optional per-queue word counters are
// built when FIFO_TO_MEM_WORD_CNT_EN is defined.
module fifo_to_mem
  import fifo_to_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 36,
  parameter int MEM_BW_WIDTH    = 4,
  parameter int FIFO_DATA_WIDTH = 144
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cal_done,
  output logic                        mem_w_n,
  input  logic                        mem_wr_full,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_ad_wr,
  output logic [MEM_DATA_WIDTH-1:0]   mem_dwl,
  output logic [MEM_DATA_WIDTH-1:0]   mem_dwh,
  output logic [MEM_BW_WIDTH-1:0]     mem_bwl_n,
  output logic [MEM_BW_WIDTH-1:0]     mem_bwh_n,
  input  logic [FIFO_DATA_WIDTH-1:0]  q0_fifo_dout,
  input  logic [FIFO_DATA_WIDTH-1:0]  q1_fifo_dout,
  input  logic [FIFO_DATA_WIDTH-1:0]  q2_fifo_dout,
  input  logic [FIFO_DATA_WIDTH-1:0]  q3_fifo_dout,
  input  logic                        q0_fifo_empty,
  input  logic                        q1_fifo_empty,
  input  logic                        q2_fifo_empty,
  input  logic                        q3_fifo_empty,
  output logic                        q0_fifo_rd_en,
  output logic                        q1_fifo_rd_en,
  output logic                        q2_fifo_rd_en,
  output logic                        q3_fifo_rd_en,
  output logic [MEM_ADDR_WIDTH-3:0]   q0_addr_tail,
  output logic [MEM_ADDR_WIDTH-3:0]   q1_addr_tail,
  output logic [MEM_ADDR_WIDTH-3:0]   q2_addr_tail,
  output logic [MEM_ADDR_WIDTH-3:0]   q3_addr_tail,
`ifdef FIFO_TO_MEM_WORD_CNT_EN
  output logic [31:0]                 q0_word_cnt,
  output logic [31:0]                 q1_word_cnt,
  output logic [31:0]                 q2_word_cnt,
  output logic [31:0]                 q3_word_cnt,
`endif
  input  logic [MEM_ADDR_WIDTH-3:0]   q0_addr_head,
  input  logic [MEM_ADDR_WIDTH-3:0]   q1_addr_head,
  input  logic [MEM_ADDR_WIDTH-3:0]   q2_addr_head,
  input  logic [MEM_ADDR_WIDTH-3:0]   q3_addr_head
);

  localparam int TAIL_W = MEM_ADDR_WIDTH - QID_W;
  localparam int HALF_W = 2 * MEM_DATA_WIDTH;

  logic [NUM_QUEUES-1:0][FIFO_DATA_WIDTH-1:0] dout;
  logic [NUM_QUEUES-1:0][TAIL_W-1:0]          head, tail_q, tail_d;
  logic [NUM_QUEUES-1:0]                      empty, elig, rd_en;

  state_e                    state_q, state_d;
  logic [QID_W-1:0]          last_grant_q, last_grant_d;
  logic [HALF_W-1:0]         hold_q, hold_d;   // beat-1 half of the popped word
  logic [HALF_W-1:0]         dw_q, dw_d;       // {dwh, dwl} of the current beat
  logic [MEM_ADDR_WIDTH-1:0] ad_q, ad_d;
  logic                      w_n_q, w_n_d;
  logic                      bw_n_q, bw_n_d;
  logic                      grant_vld, go;
  logic [QID_W-1:0]          grant_qid;

  assign dout  = {q3_fifo_dout, q2_fifo_dout, q1_fifo_dout, q0_fifo_dout};
  assign empty = {q3_fifo_empty, q2_fifo_empty, q1_fifo_empty, q0_fifo_empty};
  assign head  = {q3_addr_head, q2_addr_head, q1_addr_head, q0_addr_head};

  // A queue is eligible when it has data and its region keeps one slot free.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      elig[i] = !empty[i] && ((tail_q[i] + TAIL_W'(1)) != head[i]);
  end

  rr_arbiter4 u_arb (
    .elig       (elig),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_qid  (grant_qid)
  );

  // Grants only start bursts from S_B0; reset suppresses the pop so no word is lost to it.
  assign go = (state_q == S_B0) && cal_done && !mem_wr_full && grant_vld && !rst;

  // Burst sequencing: grant -> beat 0 next cycle -> beat 1 the cycle after.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    dw_d         = dw_q;
    ad_d         = ad_q;
    w_n_d        = 1'b1;
    bw_n_d       = 1'b1;
    tail_d       = tail_q;
    rd_en        = '0;
    case (state_q)
      S_B0: begin
        if (go) begin
          rd_en[grant_qid]  = 1'b1;
          w_n_d             = 1'b0;
          bw_n_d            = 1'b0;
          ad_d              = {grant_qid, tail_q[grant_qid]};
          dw_d              = dout[grant_qid][HALF_W-1:0];
          hold_d            = dout[grant_qid][FIFO_DATA_WIDTH-1:HALF_W];
          tail_d[grant_qid] = tail_q[grant_qid] + TAIL_W'(1);
          last_grant_d      = grant_qid;
          state_d           = S_B1;
        end
      end
      S_B1: begin
        // Beat 1 is unconditional; the controller leaves one beat of slack after full.
        dw_d    = hold_q;
        bw_n_d  = 1'b0;
        state_d = S_B0;
      end
      default: state_d = S_B0;
    endcase
  end

  // Burst state, bus outputs and tail pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_B0;
      last_grant_q <= QID_W'(NUM_QUEUES - 1);
      hold_q       <= '0;
      dw_q         <= '0;
      ad_q         <= '0;
      w_n_q        <= 1'b1;
      bw_n_q       <= 1'b1;
      tail_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      dw_q         <= dw_d;
      ad_q         <= ad_d;
      w_n_q        <= w_n_d;
      bw_n_q       <= bw_n_d;
      tail_q       <= tail_d;
    end
  end

  assign mem_w_n       = w_n_q;
  assign mem_ad_wr     = ad_q;
  assign mem_dwl       = dw_q[MEM_DATA_WIDTH-1:0];
  assign mem_dwh       = dw_q[HALF_W-1:MEM_DATA_WIDTH];
  assign mem_bwl_n     = {MEM_BW_WIDTH{bw_n_q}};
  assign mem_bwh_n     = {MEM_BW_WIDTH{bw_n_q}};
  assign q0_fifo_rd_en = rd_en[0];
  assign q1_fifo_rd_en = rd_en[1];
  assign q2_fifo_rd_en = rd_en[2];
  assign q3_fifo_rd_en = rd_en[3];
  assign q0_addr_tail  = tail_q[0];
  assign q1_addr_tail  = tail_q[1];
  assign q2_addr_tail  = tail_q[2];
  assign q3_addr_tail  = tail_q[3];

`ifdef FIFO_TO_MEM_WORD_CNT_EN
  logic [NUM_QUEUES-1:0][31:0] cnt_q, cnt_d;

  // Per-queue count of granted words, wrapping at 2^32.
  always_comb begin
    cnt_d = cnt_q;
    if (go) cnt_d[grant_qid] = cnt_q[grant_qid] + 32'd1;
  end

  // Word counter registers.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q0_word_cnt = cnt_q[0];
  assign q1_word_cnt = cnt_q[1];
  assign q2_word_cnt = cnt_q[2];
  assign q3_word_cnt = cnt_q[3];
`endif

endmodule

// File: tb/tb_fifo_to_mem.sv
// Randomized check of fifo_to_mem against a queue-level reference model.
// Address width is narrowed so tail wrap is reached in a short run.
module tb_fifo_to_mem;
  localparam int AW = 8;
  localparam int TW = AW - 2;
  localparam int M  = 1 << TW;
  localparam int DW = 36;
  localparam int HW = 2 * DW;
  localparam int FW = 144;

  logic          clk = 1'b0;
  logic          rst = 1'b1, cal_done = 1'b0, mem_wr_full = 1'b0;
  logic          mem_w_n;
  logic [AW-1:0] mem_ad_wr;
  logic [DW-1:0] mem_dwl, mem_dwh;
  logic [3:0]    mem_bwl_n, mem_bwh_n;
  logic [FW-1:0] dout [4];
  logic [3:0]    empty = 4'hF;
  logic [3:0]    rd_en;
  logic [TW-1:0] tail [4];
  logic [TW-1:0] head [4];
`ifdef FIFO_TO_MEM_WORD_CNT_EN
  logic [31:0]   wcnt [4];
  int unsigned   mcnt [4];
`endif

  always #5 clk = ~clk;

  fifo_to_mem #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cal_done(cal_done), .mem_w_n(mem_w_n),
    .mem_wr_full(mem_wr_full), .mem_ad_wr(mem_ad_wr), .mem_dwl(mem_dwl),
    .mem_dwh(mem_dwh), .mem_bwl_n(mem_bwl_n), .mem_bwh_n(mem_bwh_n),
    .q0_fifo_dout(dout[0]), .q1_fifo_dout(dout[1]),
    .q2_fifo_dout(dout[2]), .q3_fifo_dout(dout[3]),
    .q0_fifo_empty(empty[0]), .q1_fifo_empty(empty[1]),
    .q2_fifo_empty(empty[2]), .q3_fifo_empty(empty[3]),
    .q0_fifo_rd_en(rd_en[0]), .q1_fifo_rd_en(rd_en[1]),
    .q2_fifo_rd_en(rd_en[2]), .q3_fifo_rd_en(rd_en[3]),
    .q0_addr_tail(tail[0]), .q1_addr_tail(tail[1]),
    .q2_addr_tail(tail[2]), .q3_addr_tail(tail[3]),
`ifdef FIFO_TO_MEM_WORD_CNT_EN
    .q0_word_cnt(wcnt[0]), .q1_word_cnt(wcnt[1]),
    .q2_word_cnt(wcnt[2]), .q3_word_cnt(wcnt[3]),
`endif
    .q0_addr_head(head[0]), .q1_addr_head(head[1]),
    .q2_addr_head(head[2]), .q3_addr_head(head[3])
  );

  int total = 0, bad = 0;

  // Host-side FIFO contents: ring buffers with read/write counts.
  logic [FW-1:0] fbuf [4][16];
  int            frd [4], fwr [4];

  // Reference model: per-queue tail, last grant, pending beat 1, expected bus.
  int            mt [4];
  int            mlg = 3;
  bit            mbusy = 1'b0;
  logic [HW-1:0] mhold = '0, edw = '0;
  logic [AW-1:0] eaddr = '0;
  bit            ewn = 1'b1, ebw = 1'b1;
  int            hmode = 0;   // 0: heads far away, 1: random/tight, 2: set by caller

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] rword();
    return {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
  endfunction

  task automatic push(input int q, input logic [FW-1:0] w);
    if (fwr[q] - frd[q] < 16) begin
      fbuf[q][fwr[q] % 16] = w;
      fwr[q]++;
    end
  endtask

  // One clock: drive inputs, predict, check rd_en, then check the registered outputs.
  task automatic step();
    int         g;
    logic [3:0] erd;
    @(negedge clk);
    for (int q = 0; q < 4; q++) begin
      empty[q] = (fwr[q] == frd[q]);
      dout[q]  = empty[q] ? rword() : fbuf[q][frd[q] % 16];
      if (hmode == 0) head[q] = TW'((mt[q] + 20) % M);
      else if (hmode == 1) begin
        case ($urandom % 4)
          0: head[q] = TW'((mt[q] + 1) % M);
          1: head[q] = TW'((mt[q] + 2) % M);
          2: head[q] = TW'($urandom % M);
          default: ;
        endcase
      end
    end
    g = -1;
    if (!rst && !mbusy && cal_done && !mem_wr_full)
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (mlg + k) % 4;
        if (g < 0 && !empty[c] && ((mt[c] + 1) % M) != int'(head[c])) g = c;
      end
    erd = (g >= 0) ? 4'(1 << g) : 4'b0;
    #1 chk("rd_en", FW'(rd_en), FW'(erd));
    if (rst) begin
      for (int q = 0; q < 4; q++) mt[q] = 0;
`ifdef FIFO_TO_MEM_WORD_CNT_EN
      for (int q = 0; q < 4; q++) mcnt[q] = 0;
`endif
      mlg = 3; mbusy = 0; ewn = 1; eaddr = '0; edw = '0; ebw = 1;
    end else if (mbusy) begin
      ewn = 1; edw = mhold; ebw = 0; mbusy = 0;
    end else if (g >= 0) begin
      ewn   = 0;
      ebw   = 0;
      eaddr = AW'(g * M + mt[g]);
      edw   = dout[g][HW-1:0];
      mhold = dout[g][FW-1:HW];
      mt[g] = (mt[g] + 1) % M;
      mlg   = g;
      mbusy = 1;
      frd[g]++;
`ifdef FIFO_TO_MEM_WORD_CNT_EN
      mcnt[g]++;
`endif
    end else begin
      ewn = 1; ebw = 1;
    end
    @(posedge clk);
    #1;
    chk("w_n",  FW'(mem_w_n), FW'(ewn));
    chk("addr", FW'(mem_ad_wr), FW'(eaddr));
    chk("data", FW'({mem_dwh, mem_dwl}), FW'(edw));
    chk("bwl",  FW'(mem_bwl_n), FW'({4{ebw}}));
    chk("bwh",  FW'(mem_bwh_n), FW'({4{ebw}}));
    for (int q = 0; q < 4; q++) begin
      chk("tail", FW'(tail[q]), FW'(mt[q]));
`ifdef FIFO_TO_MEM_WORD_CNT_EN
      chk("wcnt", FW'(wcnt[q]), FW'(mcnt[q]));
`endif
    end
  endtask

  initial begin
    for (int q = 0; q < 4; q++) begin
      frd[q] = 0; fwr[q] = 0; mt[q] = 0; head[q] = '0; dout[q] = '0;
`ifdef FIFO_TO_MEM_WORD_CNT_EN
      mcnt[q] = 0;
`endif
    end
    // Reset state.
    repeat (3) step();
    rst = 1'b0; cal_done = 1'b1;
    step();

    // Single word on q0.
    push(0, {72'h1234_5678_9ABC_DEF0_11, 72'h00_0000_0000_AAAA_BBBB});
    repeat (4) step();

    // Two words in every queue: round-robin, back-to-back bursts.
    for (int q = 0; q < 4; q++) begin push(q, rword()); push(q, rword()); end
    repeat (20) step();

    // q2 region full: tail 5, head 6 blocks; head 7 lets exactly one word through.
    hmode = 2;
    for (int q = 0; q < 4; q++) head[q] = TW'(40);
    for (int i = 0; i < 3; i++) push(2, rword());
    repeat (10) step();
    head[2] = TW'(6);
    push(2, rword()); push(2, rword());
    repeat (10) step();
    head[2] = TW'(7);
    repeat (10) step();
    head[2] = TW'(40);
    repeat (10) step();

    // Randomized traffic with back-pressure, calibration drops and tight heads.
    hmode = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int q = 0; q < 4; q++) if ($urandom % 4 == 0) push(q, rword());
      mem_wr_full = ($urandom % 5 == 0);
      cal_done    = ($urandom % 10 != 0);
      step();
    end

    // Drain everything.
    hmode = 0; mem_wr_full = 1'b0; cal_done = 1'b1;
    repeat (200) step();

    // Reset landing on beat 0: beat 1 is dropped and arbitration restarts at q0.
    push(0, rword());
    for (int n = 0; n < 10 && !mbusy; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int q = 3; q >= 0; q--) push(q, rword());
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
